// File: rtl/dma_rd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dma_rd_pkg
//  Description : Shared types and constants for the DMA read request generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_rd_pkg;

    localparam int MRRS_MAX_CODE = 5;
    localparam int PAGE_BYTES    = 4096;
    localparam int DW_BYTES      = 4;
    localparam int CHUNK_W       = 13;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_REQ  = 3'd2,
        ST_TAG  = 3'd3,
        ST_SEND = 3'd4
    } rd_state_e;

    // Codes above 5 are reserved and behave as 4096 bytes.
    function automatic logic [CHUNK_W-1:0] mrrs_bytes(input logic [2:0] code);
        logic [2:0] c;
        c = (code > 3'(MRRS_MAX_CODE)) ? 3'(MRRS_MAX_CODE) : code;
        return 13'd128 << c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_tag_alloc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dma_tag_alloc
//  Description : Outstanding-tag bitmap with lowest-free allocation and
//                checked release.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_tag_alloc #(
    parameter int NUM_TAGS = 32,
    parameter int TAG_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_alloc,
    input  logic             i_release,
    input  logic [TAG_W-1:0] i_release_tag,
    output logic             o_free_valid,
    output logic [TAG_W-1:0] o_free_tag,
    output logic             o_tag_err
);

    localparam int IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

    logic [NUM_TAGS-1:0] r_busy;
    logic [NUM_TAGS-1:0] w_lowest;
    logic [NUM_TAGS-1:0] w_release_mask;
    logic [NUM_TAGS-1:0] w_busy_next;
    logic [IDX_W-1:0]    w_rel_idx;
    logic                w_in_range;
    logic                w_rel_hit;
    logic                w_rel_bad;

    always_comb begin
        logic found;
        found        = 1'b0;
        o_free_valid = 1'b0;
        o_free_tag   = '0;
        w_lowest     = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (!r_busy[i] && !found) begin
                found        = 1'b1;
                o_free_valid = 1'b1;
                o_free_tag   = TAG_W'(i);
                w_lowest[i]  = 1'b1;
            end
        end
    end

    // A tag being allocated this cycle is still free in the current bitmap,
    // so releasing it falls into the not-outstanding error case.
    assign w_rel_idx  = i_release_tag[IDX_W-1:0];
    assign w_in_range = (32'(i_release_tag) < 32'(NUM_TAGS));
    assign w_rel_hit  = i_release && w_in_range && r_busy[w_rel_idx];
    assign w_rel_bad  = i_release && !w_rel_hit;

    generate
        for (genvar g = 0; g < NUM_TAGS; g++) begin : g_bit
            assign w_release_mask[g] = w_rel_hit && (w_rel_idx == IDX_W'(g));
            assign w_busy_next[g]    = (r_busy[g] | (i_alloc & w_lowest[g])) & ~w_release_mask[g];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            o_tag_err <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (w_rel_bad) begin
                o_tag_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_rd_req_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dma_rd_req_gen
//  Description : Splits a DMA read job into MRRS- and 4KB-bounded MRd requests,
//                each gated by completion credit and a free tag.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_rd_req_gen
    import dma_rd_pkg::*;
#(
    parameter int NUM_TAGS = 32,
    parameter int TAG_W    = 8,
    parameter int ADDR_W   = 64
) (
    input  logic              pcie_clk,
    input  logic              pcie_rst,
    input  logic [2:0]        cfg_max_read_req,
    input  logic              dma_rd_start,
    input  logic [ADDR_W-1:0] dma_rd_addr,
    input  logic [31:0]       dma_rd_len,
    output logic              dma_rd_busy,
    output logic              dma_rd_done,
    output logic              cpld_buffer_req,
    input  logic              cpld_buffer_ack,
    input  logic              tag_rc_done,
    input  logic [TAG_W-1:0]  tag_rc_done_tag,
    output logic              rq_valid,
    input  logic              rq_ready,
    output logic [ADDR_W-1:0] rq_addr,
    output logic [10:0]       rq_len_dw,
    output logic [TAG_W-1:0]  rq_tag,
    output logic              tag_err
);

    rd_state_e          r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_remaining;
    logic [CHUNK_W-1:0] r_mrrs;
    logic [CHUNK_W-1:0] r_chunk;

    logic [CHUNK_W-1:0] w_rem13;
    logic [CHUNK_W-1:0] w_page13;
    logic [CHUNK_W-1:0] w_chunk;
    logic               w_alloc;
    logic               w_free_valid;
    logic [TAG_W-1:0]   w_free_tag;

    // Chunk = min(remaining, MRRS, bytes left in the current 4KB page).
    always_comb begin
        w_rem13  = (r_remaining >= 32'(PAGE_BYTES)) ? CHUNK_W'(PAGE_BYTES) : r_remaining[CHUNK_W-1:0];
        w_page13 = CHUNK_W'(PAGE_BYTES) - {1'b0, r_addr[11:0]};
        w_chunk  = w_rem13;
        if (r_mrrs < w_chunk) begin
            w_chunk = r_mrrs;
        end
        if (w_page13 < w_chunk) begin
            w_chunk = w_page13;
        end
    end

    assign w_alloc = (r_state == ST_TAG) && w_free_valid;

    dma_tag_alloc #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) u_tag_alloc (
        .clk           (pcie_clk),
        .rst           (pcie_rst),
        .i_alloc       (w_alloc),
        .i_release     (tag_rc_done),
        .i_release_tag (tag_rc_done_tag),
        .o_free_valid  (w_free_valid),
        .o_free_tag    (w_free_tag),
        .o_tag_err     (tag_err)
    );

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_mrrs          <= '0;
            r_chunk         <= '0;
            dma_rd_busy     <= 1'b0;
            dma_rd_done     <= 1'b0;
            cpld_buffer_req <= 1'b0;
            rq_valid        <= 1'b0;
            rq_addr         <= '0;
            rq_len_dw       <= '0;
            rq_tag          <= '0;
        end else begin
            dma_rd_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    dma_rd_busy <= 1'b0;
                    // busy is still high in the cycle after a zero-length job.
                    if (dma_rd_start && !dma_rd_busy) begin
                        r_addr      <= dma_rd_addr;
                        r_remaining <= dma_rd_len;
                        r_mrrs      <= mrrs_bytes(cfg_max_read_req);
                        dma_rd_busy <= 1'b1;
                        if (dma_rd_len == 32'd0) begin
                            dma_rd_done <= 1'b1;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_chunk         <= w_chunk;
                    cpld_buffer_req <= 1'b1;
                    r_state         <= ST_REQ;
                end
                ST_REQ: begin
                    if (cpld_buffer_ack) begin
                        cpld_buffer_req <= 1'b0;
                        r_state         <= ST_TAG;
                    end
                end
                ST_TAG: begin
                    if (w_free_valid) begin
                        rq_valid  <= 1'b1;
                        rq_addr   <= r_addr;
                        rq_len_dw <= 11'(r_chunk >> $clog2(DW_BYTES));
                        rq_tag    <= w_free_tag;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (rq_ready) begin
                        rq_valid    <= 1'b0;
                        r_addr      <= r_addr + ADDR_W'(r_chunk);
                        r_remaining <= r_remaining - 32'(r_chunk);
                        if (r_remaining == 32'(r_chunk)) begin
                            dma_rd_done <= 1'b1;
                            dma_rd_busy <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_rd_req_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dma_rd_req_gen
//  Description : Self-checking bench for dma_rd_req_gen with a job-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_rd_req_gen;

    localparam int NUM_TAGS = 32;
    localparam int TAG_W    = 8;
    localparam int ADDR_W   = 64;

    logic              pcie_clk;
    logic              pcie_rst;
    logic [2:0]        cfg_max_read_req;
    logic              dma_rd_start;
    logic [ADDR_W-1:0] dma_rd_addr;
    logic [31:0]       dma_rd_len;
    logic              dma_rd_busy;
    logic              dma_rd_done;
    logic              cpld_buffer_req;
    logic              cpld_buffer_ack;
    logic              tag_rc_done;
    logic [TAG_W-1:0]  tag_rc_done_tag;
    logic              rq_valid;
    logic              rq_ready;
    logic [ADDR_W-1:0] rq_addr;
    logic [10:0]       rq_len_dw;
    logic [TAG_W-1:0]  rq_tag;
    logic              tag_err;

    dma_rd_req_gen #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .pcie_clk         (pcie_clk),
        .pcie_rst         (pcie_rst),
        .cfg_max_read_req (cfg_max_read_req),
        .dma_rd_start     (dma_rd_start),
        .dma_rd_addr      (dma_rd_addr),
        .dma_rd_len       (dma_rd_len),
        .dma_rd_busy      (dma_rd_busy),
        .dma_rd_done      (dma_rd_done),
        .cpld_buffer_req  (cpld_buffer_req),
        .cpld_buffer_ack  (cpld_buffer_ack),
        .tag_rc_done      (tag_rc_done),
        .tag_rc_done_tag  (tag_rc_done_tag),
        .rq_valid         (rq_valid),
        .rq_ready         (rq_ready),
        .rq_addr          (rq_addr),
        .rq_len_dw        (rq_len_dw),
        .rq_tag           (rq_tag),
        .tag_err          (tag_err)
    );

    initial begin
        pcie_clk = 1'b0;
        forever #4 pcie_clk = ~pcie_clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model state ----------------
    typedef struct {
        logic [63:0] addr;
        int          dw;
    } req_t;

    typedef struct {
        logic [2:0]  cfg;
        logic [63:0] addr;
        logic [31:0] len;
        int          nreq;
        int          first_dw;
        logic [63:0] last_addr;
        int          last_dw;
    } vec_t;

    req_t exp_q[$];
    bit   model_out[NUM_TAGS];
    logic exp_err;
    int   n_checks = 0;
    int   n_fail   = 0;

    // monitor observations
    int          hs_count = 0;
    int          done_count = 0;
    int          req_rises_total = 0;
    int          req_rises_since_hs = 0;
    int          first_dw, last_dw, first_tag, last_tag;
    logic [63:0] last_addr;
    int          min_req_high = 0;
    int          min_valid_cycles = 0;

    // responder knobs
    int ack_fixed = -1, ack_cnt = 0, ack_dly = 0;
    int rdy_fixed = -1, rdy_cnt = 0, rdy_dly = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_lowest_free();
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (!model_out[i]) return i;
        end
        return -1;
    endfunction

    // Splits a job by plain arithmetic: each piece is the smallest of what is
    // left, the MRRS size and the distance to the next 4KB line.
    function automatic int build_expected(input logic [2:0] cfg, input logic [63:0] addr,
                                          input logic [31:0] len);
        logic [63:0]     a;
        longint unsigned rem, mrrs, boundary, c;
        int              n;
        req_t            r;
        a    = addr;
        rem  = longint'(len);
        mrrs = 128 << ((cfg > 5) ? 5 : cfg);
        n    = 0;
        while (rem > 0) begin
            boundary = 4096 - (a % 4096);
            c = rem;
            if (c > mrrs) c = mrrs;
            if (c > boundary) c = boundary;
            r.addr = a;
            r.dw   = int'(c / 4);
            exp_q.push_back(r);
            a   = a + c;
            rem = rem - c;
            n++;
        end
        return n;
    endfunction

    // ---------------- responders ----------------
    initial begin
        cpld_buffer_ack = 1'b0;
        forever begin
            @(posedge pcie_clk);
            #1;
            if (cpld_buffer_ack) begin
                cpld_buffer_ack = 1'b0;
            end else if (cpld_buffer_req) begin
                if (ack_cnt >= ack_dly) begin
                    cpld_buffer_ack = 1'b1;
                    ack_cnt = 0;
                    ack_dly = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    initial begin
        rq_ready = 1'b0;
        forever begin
            @(posedge pcie_clk);
            #1;
            if (rq_ready) begin
                rq_ready = 1'b0;
                rdy_cnt  = 0;
                rdy_dly  = (rdy_fixed >= 0) ? rdy_fixed : int'($urandom_range(0, 3));
            end else if (rq_valid) begin
                if (rdy_cnt >= rdy_dly) rq_ready = 1'b1;
                else rdy_cnt++;
            end else begin
                rdy_cnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic prev_req = 1'b0;
        bit   seen_fall = 1'b0;
        bit   in_req = 1'b0;
        int   low_cnt = 0, high_cnt = 0, valid_cnt = 0, cur_tag = 0;
        req_t cur_exp;
        cur_exp.addr = '0;
        cur_exp.dw   = 0;
        forever begin
            @(negedge pcie_clk);
            if (pcie_rst) begin
                prev_req = 1'b0;
                seen_fall = 1'b0;
                in_req = 1'b0;
                req_rises_since_hs = 0;
                continue;
            end
            if (cpld_buffer_req && !prev_req) begin
                req_rises_total++;
                req_rises_since_hs++;
                if (seen_fall) check("req_low_gap_ge2", 64'(low_cnt >= 2), 64'd1);
                high_cnt = 0;
            end
            if (!cpld_buffer_req && prev_req) begin
                seen_fall = 1'b1;
                low_cnt = 0;
                if (min_req_high > 0) check("req_held_until_ack", 64'(high_cnt >= min_req_high), 64'd1);
            end
            if (cpld_buffer_req) high_cnt++;
            else low_cnt++;
            prev_req = cpld_buffer_req;

            if (rq_valid) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    valid_cnt = 0;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rq_unexpected: got request at 0x%0h expected none", rq_addr);
                        cur_exp.addr = '0;
                        cur_exp.dw = 0;
                        cur_tag = 0;
                    end else begin
                        cur_exp = exp_q.pop_front();
                        cur_tag = model_lowest_free();
                        if (cur_tag >= 0) model_out[cur_tag] = 1'b1;
                    end
                end
                valid_cnt++;
                check("rq_addr", rq_addr, cur_exp.addr);
                check("rq_len_dw", 64'(rq_len_dw), 64'(cur_exp.dw));
                check("rq_tag", 64'(rq_tag), 64'(cur_tag));
                if (rq_ready) begin
                    check("one_req_rise_per_rq", 64'(req_rises_since_hs), 64'd1);
                    req_rises_since_hs = 0;
                    if (min_valid_cycles > 0) check("rq_stall_len", 64'(valid_cnt >= min_valid_cycles), 64'd1);
                    if (hs_count == 0) begin
                        first_dw  = int'(rq_len_dw);
                        first_tag = int'(rq_tag);
                    end
                    last_addr = rq_addr;
                    last_dw   = int'(rq_len_dw);
                    last_tag  = int'(rq_tag);
                    hs_count++;
                    in_req = 1'b0;
                end
            end
            if (dma_rd_done) done_count++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_job(input logic [2:0] cfg, input logic [63:0] addr, input logic [31:0] len);
        @(posedge pcie_clk);
        #1;
        cfg_max_read_req = cfg;
        dma_rd_addr      = addr;
        dma_rd_len       = len;
        dma_rd_start     = 1'b1;
        @(posedge pcie_clk);
        #1;
        dma_rd_start     = 1'b0;
        cfg_max_read_req = 3'($urandom);
        dma_rd_addr      = {$urandom, $urandom};
        dma_rd_len       = $urandom;
    endtask

    task automatic wait_done(input int base, input int maxc);
        for (int i = 0; i < maxc && done_count == base; i++) begin
            @(negedge pcie_clk);
            #1;
        end
        repeat (3) @(negedge pcie_clk);
        #1;
        check("done_pulse_count", 64'(done_count - base), 64'd1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("busy_after_done", 64'(dma_rd_busy), 64'd0);
    endtask

    task automatic wait_hs(input int n, input int maxc, input string name);
        for (int i = 0; i < maxc && hs_count < n; i++) begin
            @(negedge pcie_clk);
            #1;
        end
        check(name, 64'(hs_count), 64'(n));
    endtask

    task automatic run_job(input logic [2:0] cfg, input logic [63:0] addr, input logic [31:0] len,
                           output int nreq);
        int base;
        nreq = build_expected(cfg, addr, len);
        hs_count = 0;
        req_rises_total = 0;
        base = done_count;
        start_job(cfg, addr, len);
        wait_done(base, 3000);
    endtask

    task automatic release_tag(input int t);
        @(posedge pcie_clk);
        #1;
        tag_rc_done     = 1'b1;
        tag_rc_done_tag = TAG_W'(t);
        @(posedge pcie_clk);
        #1;
        tag_rc_done = 1'b0;
        if (t < NUM_TAGS && model_out[t]) model_out[t] = 1'b0;
        else exp_err = 1'b1;
        @(negedge pcie_clk);
        check("tag_err", 64'(tag_err), 64'(exp_err));
    endtask

    task automatic free_all();
        int q[$];
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (model_out[i]) q.push_back(i);
        end
        while (q.size() > 0) begin
            int k;
            k = int'($urandom_range(0, q.size() - 1));
            release_tag(q[k]);
            q.delete(k);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_TAGS; i++) model_out[i] = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"}, 64'(dma_rd_busy), 64'd0);
        check({pfx, "_done"}, 64'(dma_rd_done), 64'd0);
        check({pfx, "_req"}, 64'(cpld_buffer_req), 64'd0);
        check({pfx, "_valid"}, 64'(rq_valid), 64'd0);
        check({pfx, "_addr"}, rq_addr, 64'd0);
        check({pfx, "_len"}, 64'(rq_len_dw), 64'd0);
        check({pfx, "_tag"}, 64'(rq_tag), 64'd0);
        check({pfx, "_tag_err"}, 64'(tag_err), 64'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t vecs[6];
        int   nreq, base;

        vecs[0] = '{cfg: 3'd0, addr: 64'h1000, len: 32'd512, nreq: 4, first_dw: 32,
                    last_addr: 64'h1180, last_dw: 32};
        vecs[1] = '{cfg: 3'd2, addr: 64'h0F80, len: 32'd1024, nreq: 3, first_dw: 32,
                    last_addr: 64'h1200, last_dw: 96};
        vecs[2] = '{cfg: 3'd7, addr: 64'h0, len: 32'd8192, nreq: 2, first_dw: 1024,
                    last_addr: 64'h1000, last_dw: 1024};
        vecs[3] = '{cfg: 3'd5, addr: 64'h0FFC, len: 32'd8, nreq: 2, first_dw: 1,
                    last_addr: 64'h1000, last_dw: 1};
        vecs[4] = '{cfg: 3'd1, addr: 64'h1_0000_0F00, len: 32'h300, nreq: 3, first_dw: 64,
                    last_addr: 64'h1_0000_1100, last_dw: 64};
        vecs[5] = '{cfg: 3'd0, addr: 64'h40, len: 32'd0, nreq: 0, first_dw: 0,
                    last_addr: 64'h0, last_dw: 0};

        pcie_rst = 1'b1;
        cfg_max_read_req = '0;
        dma_rd_start = 1'b0;
        dma_rd_addr = '0;
        dma_rd_len = '0;
        tag_rc_done = 1'b0;
        tag_rc_done_tag = '0;
        clear_model();
        repeat (3) @(posedge pcie_clk);
        #1;
        pcie_rst = 1'b0;
        @(negedge pcie_clk);
        check_all_zero("reset");

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].cfg, vecs[i].addr, vecs[i].len, nreq);
            check("vec_model_nreq", 64'(nreq), 64'(vecs[i].nreq));
            check("vec_nreq", 64'(hs_count), 64'(vecs[i].nreq));
            check("vec_req_rises", 64'(req_rises_total), 64'(vecs[i].nreq));
            if (vecs[i].nreq > 0) begin
                check("vec_first_dw", 64'(first_dw), 64'(vecs[i].first_dw));
                check("vec_first_tag", 64'(first_tag), 64'd0);
                check("vec_last_addr", last_addr, vecs[i].last_addr);
                check("vec_last_dw", 64'(last_dw), 64'(vecs[i].last_dw));
            end
            free_all();
        end

        // Tag exhaustion: 34 requests with 32 tags
        nreq = build_expected(3'd0, 64'h8000, 32'd4352);
        check("exh_model_nreq", 64'(nreq), 64'd34);
        hs_count = 0;
        base = done_count;
        start_job(3'd0, 64'h8000, 32'd4352);
        wait_hs(32, 2000, "exh_first_32");
        repeat (15) @(negedge pcie_clk);
        check("exh_stalled_hs", 64'(hs_count), 64'd32);
        check("exh_stalled_req_low", 64'(cpld_buffer_req), 64'd0);
        check("exh_stalled_no_valid", 64'(rq_valid), 64'd0);
        check("exh_stalled_busy", 64'(dma_rd_busy), 64'd1);
        // a start while busy must not disturb the running job
        start_job(3'd3, 64'hABC0, 32'd64);
        release_tag(5);
        wait_hs(33, 200, "exh_after_free5");
        check("exh_tag_reuse_5", 64'(last_tag), 64'd5);
        release_tag(0);
        wait_done(base, 500);
        check("exh_tag_reuse_0", 64'(last_tag), 64'd0);
        free_all();
        release_tag(5);  // idle tag

        // Slow credit and slow formatter
        ack_fixed = 20; ack_dly = 20; ack_cnt = 0;
        rdy_fixed = 5;  rdy_dly = 5;  rdy_cnt = 0;
        min_req_high = 20;
        min_valid_cycles = 6;
        run_job(3'd0, 64'h2000, 32'd256, nreq);
        check("stall_nreq", 64'(hs_count), 64'd2);
        ack_fixed = -1; ack_dly = 0;
        rdy_fixed = -1; rdy_dly = 0;
        min_req_high = 0;
        min_valid_cycles = 0;
        free_all();

        // Reset while parked in SEND
        rdy_fixed = 100000; rdy_dly = 100000;
        nreq = build_expected(3'd3, 64'h3000, 32'd2048);
        hs_count = 0;
        start_job(3'd3, 64'h3000, 32'd2048);
        for (int i = 0; i < 200 && !rq_valid; i++) @(negedge pcie_clk);
        check("rst_reached_send", 64'(rq_valid), 64'd1);
        repeat (3) @(negedge pcie_clk);
        @(posedge pcie_clk);
        #1;
        pcie_rst = 1'b1;
        base = done_count;
        @(posedge pcie_clk);
        @(negedge pcie_clk);
        check_all_zero("midrst");
        #1;
        pcie_rst = 1'b0;
        clear_model();
        rdy_fixed = -1; rdy_dly = 0;
        repeat (20) @(negedge pcie_clk);
        check("midrst_no_done", 64'(done_count - base), 64'd0);
        release_tag(40);  // out of range
        run_job(3'd0, 64'h4000, 32'd256, nreq);
        check("midrst_restart_tag0", 64'(first_tag), 64'd0);
        free_all();

        // Randomized jobs against the model
        for (int j = 0; j < 25; j++) begin
            logic [2:0]  cfg;
            logic [63:0] addr;
            logic [31:0] len;
            int          nexp;
            cfg  = 3'($urandom_range(0, 7));
            addr = {$urandom, $urandom} & ~64'h3;
            if (j % 2 == 0) addr[11:0] = 12'(4096 - 4 * int'($urandom_range(1, 64)));
            len  = 32'(4 * $urandom_range(0, 512));
            run_job(cfg, addr, len, nexp);
            check("rand_nreq", 64'(hs_count), 64'(nexp));
            free_all();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
